// File: rtl/fft_output_buffer_pkg.sv
// Shared types for the FFT output double buffer:
// bank/read-FSM state encodings and the bit-reverse helper.
package fft_output_buffer_pkg;

    localparam int MAX_LOG2N = 8;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PULSE,
        R_WAIT
    } rd_state_e;

    // Reverses the low lg bits of k; upper bits come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(
        input logic [MAX_LOG2N-1:0] k,
        input int lg
    );
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < lg) r[i] = k[3'(lg - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_buffer_if.sv
// Sample handshake between the FFT core (master)
// and the output buffer (slave).
interface fft_output_buffer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_real;
    logic signed [DATA_WIDTH-1:0] in_imag;

    modport master (
        output in_valid, in_real, in_imag,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_real, in_imag,
        output in_ready
    );
endinterface

// File: rtl/fft_bank_regfile.sv
// One frame bank: N complex entries, a single write port
// and every entry visible in parallel.
module fft_bank_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(N)-1:0]         waddr,
    input  logic signed [DATA_WIDTH-1:0] wr_real,
    input  logic signed [DATA_WIDTH-1:0] wr_imag,
    output logic signed [DATA_WIDTH-1:0] rd_real [0:N-1],
    output logic signed [DATA_WIDTH-1:0] rd_imag [0:N-1]
);
    logic signed [DATA_WIDTH-1:0] real_q [0:N-1];
    logic signed [DATA_WIDTH-1:0] real_d [0:N-1];
    logic signed [DATA_WIDTH-1:0] imag_q [0:N-1];
    logic signed [DATA_WIDTH-1:0] imag_d [0:N-1];

    always_comb begin
        real_d = real_q;
        imag_d = imag_q;
        if (we) begin
            real_d[waddr] = wr_real;
            imag_d[waddr] = wr_imag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                real_q[i] <= '0;
                imag_q[i] <= '0;
            end
        end else begin
            real_q <= real_d;
            imag_q <= imag_d;
        end
    end

    assign rd_real = real_q;
    assign rd_imag = imag_q;

endmodule

// File: rtl/fft_output_buffer.sv
// Ping-pong frame buffer behind an FFT core: reorders samples into
// natural order and holds each frame until downstream releases it.
module fft_output_buffer
    import fft_output_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    fft_output_buffer_if.slave           in_if,
    output logic                         buffer_ready,
    output logic signed [DATA_WIDTH-1:0] real_out [0:N-1],
    output logic signed [DATA_WIDTH-1:0] imag_out [0:N-1],
    input  logic                         xfer_done,
    output logic                         frame_drop
);
    localparam int AW = $clog2(N);
    localparam int SW = AW + 1;

    bank_state_e   bank_q [0:1];
    bank_state_e   bank_d [0:1];
    rd_state_e     rd_q, rd_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_sel_q, rd_sel_d;
    logic          drop_q, drop_d;
    logic [SW-1:0] stall_q, stall_d;

    logic          in_ready;
    logic          accept;
    logic          stall;
    logic          full_a, full_b, pick;
    logic [AW-1:0] waddr;

    logic signed [DATA_WIDTH-1:0] a_real [0:N-1];
    logic signed [DATA_WIDTH-1:0] a_imag [0:N-1];
    logic signed [DATA_WIDTH-1:0] b_real [0:N-1];
    logic signed [DATA_WIDTH-1:0] b_imag [0:N-1];

    assign in_ready = (bank_q[wr_ptr_q] == B_EMPTY) ||
                      (bank_q[wr_ptr_q] == B_FILLING);
    assign in_if.in_ready = in_ready;
    assign accept = in_if.in_valid && in_ready;
    assign stall  = in_if.in_valid && !in_ready;

    assign waddr = (BIT_REVERSE != 0) ?
                   AW'(bitrev(MAX_LOG2N'(wr_cnt_q), AW)) : wr_cnt_q;

    // With both banks full the write pointer has already moved
    // back onto the older one.
    assign full_a = (bank_q[0] == B_FULL);
    assign full_b = (bank_q[1] == B_FULL);
    assign pick   = (full_a && full_b) ? wr_ptr_q : full_b;

    always_comb begin
        bank_d   = bank_q;
        rd_d     = rd_q;
        wr_cnt_d = wr_cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_sel_d = rd_sel_q;
        drop_d   = drop_q;
        stall_d  = '0;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == AW'(N - 1)) begin
                bank_d[wr_ptr_q] = B_FULL;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                bank_d[wr_ptr_q] = B_FILLING;
            end
        end

        unique case (rd_q)
            R_IDLE: begin
                if (full_a || full_b) begin
                    rd_sel_d     = pick;
                    bank_d[pick] = B_READING;
                    rd_d         = R_PULSE;
                end
            end
            R_PULSE: rd_d = R_WAIT;
            R_WAIT: begin
                if (xfer_done) begin
                    bank_d[rd_sel_q] = B_EMPTY;
                    rd_d             = R_IDLE;
                end
            end
            default: rd_d = R_IDLE;
        endcase

        if (stall) begin
            stall_d = (stall_q == SW'(N)) ? stall_q : stall_q + 1'b1;
            if (stall_q == SW'(N - 1)) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0] <= B_EMPTY;
            bank_q[1] <= B_EMPTY;
            rd_q      <= R_IDLE;
            wr_cnt_q  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            drop_q    <= 1'b0;
            stall_q   <= '0;
        end else begin
            bank_q    <= bank_d;
            rd_q      <= rd_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_sel_q  <= rd_sel_d;
            drop_q    <= drop_d;
            stall_q   <= stall_d;
        end
    end

    fft_bank_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N)
    ) u_bank_a (
        .clk    (clk),
        .reset  (reset),
        .we     (accept && !wr_ptr_q),
        .waddr  (waddr),
        .wr_real(in_if.in_real),
        .wr_imag(in_if.in_imag),
        .rd_real(a_real),
        .rd_imag(a_imag)
    );

    fft_bank_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .N         (N)
    ) u_bank_b (
        .clk    (clk),
        .reset  (reset),
        .we     (accept && wr_ptr_q),
        .waddr  (waddr),
        .wr_real(in_if.in_real),
        .wr_imag(in_if.in_imag),
        .rd_real(b_real),
        .rd_imag(b_imag)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            real_out[i] = rd_sel_q ? b_real[i] : a_real[i];
            imag_out[i] = rd_sel_q ? b_imag[i] : a_imag[i];
        end
    end

    assign buffer_ready = (rd_q == R_PULSE);
    assign frame_drop   = drop_q;

endmodule

// File: tb/tb_fft_output_buffer.sv
// Bench for fft_output_buffer: bit-reversed and natural-order
// instances, frame scoreboard plus hand-timed corner sequences.
module tb_fft_output_buffer;
    localparam int DW = 16;
    localparam int NP = 16;

    typedef struct packed {
        int re0;
        int rstep;
        int im0;
        int istep;
        int idx;
        int xre;
        int xim;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fft_output_buffer_if #(.DATA_WIDTH(DW)) v0 ();
    fft_output_buffer_if #(.DATA_WIDTH(DW)) v1 ();

    logic br0, br1, fd0, fd1;
    logic xd0 = 1'b0;
    logic xd1 = 1'b0;
    logic signed [DW-1:0] ro0 [0:NP-1];
    logic signed [DW-1:0] io0 [0:NP-1];
    logic signed [DW-1:0] ro1 [0:NP-1];
    logic signed [DW-1:0] io1 [0:NP-1];

    fft_output_buffer #(.DATA_WIDTH(DW), .N(NP), .BIT_REVERSE(1)) dut0 (
        .clk(clk), .reset(reset), .in_if(v0), .buffer_ready(br0),
        .real_out(ro0), .imag_out(io0), .xfer_done(xd0), .frame_drop(fd0)
    );

    fft_output_buffer #(.DATA_WIDTH(DW), .N(NP), .BIT_REVERSE(0)) dut1 (
        .clk(clk), .reset(reset), .in_if(v1), .buffer_ready(br1),
        .real_out(ro1), .imag_out(io1), .xfer_done(xd1), .frame_drop(fd1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    logic [NP*DW-1:0] exp_re_q [$];
    logic [NP*DW-1:0] exp_im_q [$];
    logic [NP*DW-1:0] mon_er, mon_ei;
    int mon_bad;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int brev4(input int k);
        return {28'd0, k[0], k[1], k[2], k[3]};
    endfunction

    function automatic int nonzero0();
        int c = 0;
        for (int k = 0; k < NP; k++)
            if (ro0[k] !== 16'sd0 || io0[k] !== 16'sd0) c++;
        return c;
    endfunction

    function automatic int errs1(input int r0, input int i0);
        int c = 0;
        for (int k = 0; k < NP; k++) begin
            if (ro1[k] !== 16'(r0 + k)) c++;
            if (io1[k] !== 16'(i0 + k)) c++;
        end
        return c;
    endfunction

    // Scoreboard: each buffer_ready pulse pops the oldest expected frame.
    always @(negedge clk) begin
        if (br0 === 1'b1) begin
            pulses0++;
            n_cmp++;
            if (exp_re_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_pulse: got unexpected buffer_ready want none");
            end else begin
                mon_er = exp_re_q.pop_front();
                mon_ei = exp_im_q.pop_front();
                mon_bad = -1;
                for (int k = NP - 1; k >= 0; k--)
                    if (ro0[k] !== mon_er[k*DW +: DW] ||
                        io0[k] !== mon_ei[k*DW +: DW]) mon_bad = k;
                if (mon_bad >= 0) begin
                    n_bad++;
                    $display("FAIL sb_frame[%0d]: got %0d/%0d want %0d/%0d",
                             mon_bad, ro0[mon_bad], io0[mon_bad],
                             $signed(mon_er[mon_bad*DW +: DW]),
                             $signed(mon_ei[mon_bad*DW +: DW]));
                end
            end
        end
        if (br1 === 1'b1) pulses1++;
    end

    task automatic push(input logic signed [DW-1:0] re, im,
                        input bit xf, output bit ok);
        v0.in_valid = 1'b1;
        v0.in_real  = re;
        v0.in_imag  = im;
        xd0 = xf;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (v0.in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        v0.in_valid = 1'b0;
        xd0 = 1'b0;
    endtask

    task automatic push1(input logic signed [DW-1:0] re, im, output bit ok);
        v1.in_valid = 1'b1;
        v1.in_real  = re;
        v1.in_imag  = im;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (v1.in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        v1.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int re0, rs, im0, is, input bit xf_last);
        logic [NP*DW-1:0] er = '0;
        logic [NP*DW-1:0] ei = '0;
        logic signed [DW-1:0] r, i;
        bit ok;
        bit all_ok = 1'b1;
        for (int k = 0; k < NP; k++) begin
            r = 16'(re0 + rs * k);
            i = 16'(im0 + is * k);
            er[brev4(k)*DW +: DW] = r;
            ei[brev4(k)*DW +: DW] = i;
            if (k == NP - 1) begin
                exp_re_q.push_back(er);
                exp_im_q.push_back(ei);
            end
            push(r, i, xf_last && (k == NP - 1), ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
        end
        chk("frame_accepted", all_ok, 1);
    endtask

    task automatic send_frame1(input int r0, i0);
        bit ok;
        bit all_ok = 1'b1;
        for (int k = 0; k < NP; k++) begin
            push1(16'(r0 + k), 16'(i0 + k), ok);
            if (!ok) begin
                all_ok = 1'b0;
                break;
            end
        end
        chk("frame1_accepted", all_ok, 1);
    endtask

    task automatic xfer0();
        xd0 = 1'b1;
        tick();
        xd0 = 1'b0;
    endtask

    task automatic xfer1();
        xd1 = 1'b1;
        tick();
        xd1 = 1'b0;
    endtask

    task automatic wait_pulse(input bit which, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if ((which ? br1 : br0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int pc;
        v0.in_valid = 1'b0; v0.in_real = '0; v0.in_imag = '0;
        v1.in_valid = 1'b0; v1.in_real = '0; v1.in_imag = '0;
        tbl[0] = '{0, 1, 0, -1, 8, 1, -1};
        tbl[1] = '{1000, 7, -500, 3, 4, 1014, -494};
        tbl[2] = '{-32768, 4096, 32767, -4096, 15, 28672, -28673};
        tbl[3] = '{12345, -1111, -7, 2000, 1, 3457, 15993};

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_buffer_ready", br0, 0);
        chk("rst_frame_drop", fd0, 0);
        chk("rst_in_ready", v0.in_ready, 1);
        chk("rst_outputs_zero", nonzero0(), 0);

        // Latency and bit-reversed placement per table record.
        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t].re0, tbl[t].rstep, tbl[t].im0, tbl[t].istep, 1'b0);
            chk("lat_e0", br0, 0);
            tick();
            chk("lat_e1", br0, 1);
            tick();
            chk("lat_e2", br0, 0);
            chk("elem_re", ro0[tbl[t].idx], tbl[t].xre);
            chk("elem_im", io0[tbl[t].idx], tbl[t].xim);
            xfer0();
        end

        // Three frames without release: third blocks until one xfer_done.
        send_frame(2000, 1, -2000, -1, 1'b0);
        send_frame(3000, 2, 100, 5, 1'b0);
        v0.in_valid = 1'b1;
        v0.in_real  = 16'sd7;
        repeat (3) tick();
        chk("f3_blocked", v0.in_ready, 0);
        xfer0();
        send_frame(4000, 3, -50, 7, 1'b0);
        xfer0();
        wait_pulse(1'b0, ok);
        chk("f3_pulse", ok, 1);
        tick();
        xfer0();

        // Last sample of frame 2 and release of frame 1 on one edge.
        send_frame(5, 5, -5, -5, 1'b0);
        send_frame(77, -3, 9, 11, 1'b1);
        chk("sim_in_ready", v0.in_ready, 1);
        chk("sim_e0", br0, 0);
        tick();
        chk("sim_e1", br0, 1);
        tick();
        chk("sim_e2", br0, 0);
        xfer0();

        // Held in_valid while both banks occupied sets sticky frame_drop.
        send_frame(-300, 9, 600, -2, 1'b0);
        send_frame(321, 4, -321, -4, 1'b0);
        v0.in_valid = 1'b1;
        repeat (15) tick();
        chk("drop_pre", fd0, 0);
        tick();
        chk("drop_set", fd0, 1);
        v0.in_valid = 1'b0;
        xfer0();
        wait_pulse(1'b0, ok);
        chk("drop_release_pulse", ok, 1);
        tick();
        xfer0();
        chk("drop_sticky", fd0, 1);

        // Reset in the middle of a frame.
        for (int k = 0; k < 7; k++) push(16'(900 + k), 16'(-900 - k), 1'b0, ok);
        reset = 1'b1;
        tick();
        chk("rstmid_zero", nonzero0(), 0);
        tick();
        reset = 1'b0;
        chk("rstmid_drop_clr", fd0, 0);
        chk("rstmid_in_ready", v0.in_ready, 1);
        chk("rstmid_br", br0, 0);
        pc = pulses0;
        repeat (20) tick();
        chk("rstmid_no_pulse", pulses0, pc);
        send_frame(-100, 13, 250, -17, 1'b0);
        wait_pulse(1'b0, ok);
        chk("rstmid_pulse", ok, 1);
        tick();
        chk("rstmid_one_pulse", pulses0, pc + 1);
        xfer0();

        // Natural-order instance; xfer_done during the pulse is ignored.
        send_frame1(100, 300);
        wait_pulse(1'b1, ok);
        chk("nat_pulse", ok, 1);
        chk("nat_order", errs1(100, 300), 0);
        xfer1();
        send_frame1(500, 700);
        repeat (4) tick();
        chk("nat_pulse_count", pulses1, 1);
        chk("nat_hold", errs1(100, 300), 0);
        xfer1();
        wait_pulse(1'b1, ok);
        chk("nat_pulse2", ok, 1);
        chk("nat_second", errs1(500, 700), 0);
        tick();
        xfer1();
        repeat (4) tick();
        chk("nat_pulse_total", pulses1, 2);

        chk("sb_drained", exp_re_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_output_buffer.md
FFT_OUTPUT_BUFFER -- requirements
Module: fft_output_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed sample width of real and imaginary parts.
REQ-002 Parameter N, default 16, points per frame; power of two, 4..256.
REQ-003 Parameter BIT_REVERSE, default 1, 1 = input arrives in bit-reversed order, 0 = natural order.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in_valid  input  1  FFT core presents a sample.
REQ-007 in_ready  output  1  buffer accepts the sample this cycle.
REQ-008 in_real / in_imag  input  DATA_WIDTH each, signed  FFT output sample.
REQ-009 buffer_ready  output  1  one-cycle pulse: a full frame is on real_out/imag_out.
REQ-010 real_out / imag_out  output  unpacked arrays [0:N-1] of signed DATA_WIDTH  frame in natural order.
REQ-011 xfer_done  input  1  downstream transfer finished; releases the presented frame.
REQ-012 frame_drop  output  1  sticky: in_valid was held low-ready for a full N-cycle window (status only).

Function
REQ-013 Two banks (A, B), each N real + N imag registers; each bank state EMPTY, FILLING, FULL, READING.
REQ-014 A sample is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-015 Write counter wr_cnt (log2 N bits) counts accepted samples; sample k is written to address bitrev(k) if BIT_REVERSE=1, else to k.
REQ-016 On acceptance with wr_cnt=N-1: wr_cnt wraps to 0, the write bank becomes FULL, write bank pointer toggles.
REQ-017 in_ready = 1 iff the current write bank is EMPTY or FILLING; combinational from registered state only.
REQ-018 Read FSM states: R_IDLE, R_PULSE, R_WAIT.
REQ-019 R_IDLE -> R_PULSE when either bank is FULL; oldest FULL bank becomes READING and is selected onto real_out/imag_out.
REQ-020 buffer_ready = 1 only in R_PULSE; R_PULSE -> R_WAIT unconditionally after one cycle.
REQ-021 R_WAIT -> R_IDLE when xfer_done=1; READING bank becomes EMPTY on that edge.
REQ-022 Latency: last sample accepted at edge E with read FSM in R_IDLE -> buffer_ready high from edge E+1 to edge E+2.
REQ-023 real_out/imag_out hold the READING bank unchanged from the R_PULSE entry until the xfer_done edge; no write ever targets a READING bank.
REQ-024 xfer_done in R_IDLE or R_PULSE is ignored.
REQ-025 Simultaneous: last-sample acceptance into one bank and xfer_done releasing the other on the same edge -> both transitions take effect; next frame pulses at the following edge+1.
REQ-026 Both banks FULL/READING -> in_ready=0; writing resumes on the cycle after xfer_done frees a bank.
REQ-027 frame_drop sets when in_valid=1 and in_ready=0 for N consecutive cycles; cleared only by reset.
REQ-028 No arithmetic on samples; values stored bit-exact.

Reset
REQ-029 On reset: both banks EMPTY, write pointer = A, wr_cnt=0, read FSM R_IDLE, buffer_ready=0, frame_drop=0, all bank registers 0 (so real_out/imag_out=0), in_ready=1 after release.
REQ-030 Reset mid-frame discards all partial and full frames; no buffer_ready pulse follows reset until N new samples are accepted.

Structure
REQ-031 Shared package holds the bank-state enum, read-FSM enum, and a bitrev function parameterised by log2 N.
REQ-032 One sub-module, fft_bank_regfile (N-entry complex register array, one write port, full parallel read), instantiated twice.

Verification
REQ-033 N=16, BIT_REVERSE=1, feed k=0..15 with in_real=k, in_imag=-k back-to-back -> one buffer_ready pulse at E+1; real_out[bitrev(k)]=k, e.g. real_out[8]=1, imag_out[8]=-1.
REQ-034 Feed 3 frames without xfer_done -> frames 1,2 accepted, in_ready=0 at start of frame 3; xfer_done once -> frame 2 pulsed, frame 3 accepted.
REQ-035 xfer_done on same edge as frame-2 last sample -> bank A EMPTY and B FULL together; buffer_ready next-cycle-plus-one, real_out shows frame 2.
REQ-036 Assert reset after 7 samples of frame 1 -> outputs all 0, no pulse; 16 new samples -> exactly one pulse with new data only.
REQ-037 in_valid=1 held while both banks occupied for 16 cycles -> frame_drop=1 and stays 1 until reset.
REQ-038 BIT_REVERSE=0, inputs 100..115 -> real_out[k]=100+k; xfer_done during R_PULSE ignored, arrays stable until later xfer_done.
